// File: rtl/bus_if_types_pkg.sv
// Shared bus attribute types and the byte-enable helper for the data-memory controller.
package bus_if_types_pkg;

    typedef enum logic {
        TtypeRead  = 1'b0,
        TtypeWrite = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } tsize_e;

    // Byte lanes touched by an access of the given size starting at the given lane.
    function automatic logic [3:0] be_from(tsize_e tsize, logic [1:0] lane);
        logic [3:0] be;
        case (tsize)
            SizeByte: be = 4'b0001 << lane;
            SizeHalf: be = 4'b0011 << lane;
            SizeWord: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a master and the data-memory controller.
interface dmem_ctrl_if;
    import bus_if_types_pkg::*;

    logic        bstart;
    logic        breq;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    logic        berr;

    modport master (
        output bstart, breq, ttype, tsize, addr, wdata,
        input  rdata, bdone, berr
    );

    modport slave (
        input  bstart, breq, ttype, tsize, addr, wdata,
        output rdata, bdone, berr
    );

endinterface

// File: rtl/sram_be.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
module sram_be #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [3:0]       be_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one bus transfer at a time, waits a fixed number of
// cycles, then performs the byte/half/word access on the SRAM and pulses bdone.
module dmem_ctrl
    import bus_if_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    ttype_e      ttype_q;
    tsize_e      tsize_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        bdone_q;
    logic        berr_q;
    logic        rd_valid_q;
    logic [1:0]  rd_lane_q;
    tsize_e      rd_size_q;

    ttype_e      cur_ttype;
    tsize_e      cur_tsize;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] offset;
    logic [1:0]  lane;
    logic        cur_err;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic        go_done;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;
    logic        unused_breq;

    assign unused_breq = bus.breq;

    // Attributes of the access happening on this edge: live inputs when a zero-wait transfer
    // goes straight from IDLE to DONE, otherwise the values latched at acceptance.
    always_comb begin
        if (state_q == StIdle) begin
            cur_ttype = bus.ttype;
            cur_tsize = bus.tsize;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end else begin
            cur_ttype = ttype_q;
            cur_tsize = tsize_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Address decode, alignment/range error check and write-lane placement.
    always_comb begin
        offset  = cur_addr - BASE_ADDR;
        lane    = offset[1:0];
        cur_err = 1'b0;
        case (cur_tsize)
            SizeByte: cur_err = 1'b0;
            SizeHalf: cur_err = lane[0];
            SizeWord: cur_err = (lane != 2'b00);
            default:  cur_err = 1'b1;
        endcase
        if (cur_addr < BASE_ADDR) begin
            cur_err = 1'b1;
        end
        if ({2'b00, offset[31:2]} >= DEPTH_WORDS) begin
            cur_err = 1'b1;
        end
        be       = be_from(cur_tsize, lane);
        wdata_sh = cur_wdata << {lane, 3'b000};
    end

    // The edge on which the transfer enters DONE and touches memory.
    always_comb begin
        go_done = 1'b0;
        if (state_q == StIdle && bus.bstart && WAIT_STATES == 0) begin
            go_done = 1'b1;
        end
        if (state_q == StAccess && cnt_q == 4'd0) begin
            go_done = 1'b1;
        end
        // Reset wins over a completing transfer: nothing is written or read.
        mem_we = go_done && !rst && !cur_err && (cur_ttype == TtypeWrite);
        mem_re = go_done && !rst && !cur_err && (cur_ttype == TtypeRead);
    end

    sram_be #(
        .Depth (DEPTH_WORDS),
        .AddrW (AW)
    ) u_sram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .be_i    (be),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (wdata_sh),
        .rdata_o (mem_rdata)
    );

    // Transfer FSM with registered response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            ttype_q    <= TtypeRead;
            tsize_q    <= SizeByte;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            bdone_q    <= 1'b0;
            berr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_lane_q  <= 2'd0;
            rd_size_q  <= SizeByte;
        end else begin
            bdone_q <= 1'b0;
            berr_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.bstart) begin
                        ttype_q <= bus.ttype;
                        tsize_q <= bus.tsize;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        if (WAIT_STATES == 0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StAccess;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (go_done) begin
                bdone_q    <= 1'b1;
                berr_q     <= cur_err;
                rd_valid_q <= !cur_err && (cur_ttype == TtypeRead);
                rd_lane_q  <= lane;
                rd_size_q  <= cur_tsize;
            end
        end
    end

    // The SRAM read register only loads on DONE, so it together with the lane/size captured
    // on that edge holds the response until the next DONE.
    always_comb begin
        rd_shifted = mem_rdata >> {rd_lane_q, 3'b000};
        case (rd_size_q)
            SizeByte: rd_ext = {24'd0, rd_shifted[7:0]};
            SizeHalf: rd_ext = {16'd0, rd_shifted[15:0]};
            default:  rd_ext = rd_shifted;
        endcase
        bus.rdata = rd_valid_q ? rd_ext : 32'd0;
    end

    assign bus.bdone = bdone_q;
    assign bus.berr  = berr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic checked against a
// byte-level memory model, on a one-wait-state instance and a zero-wait offset instance.
module tb_dmem_ctrl;
    import bus_if_types_pkg::*;

    localparam int unsigned WS1    = 1;
    localparam int unsigned DEPTH1 = 1024;
    localparam logic [31:0] BASE1  = 32'h0000_0000;
    localparam int unsigned WS0    = 0;
    localparam int unsigned DEPTH0 = 64;
    localparam logic [31:0] BASE0  = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   pending_done = 1'b0;

    logic [31:0] m1 [DEPTH1];
    logic [31:0] m0 [DEPTH0];

    dmem_ctrl_if bus1 ();
    dmem_ctrl_if bus0 ();

    dmem_ctrl #(
        .DEPTH_WORDS (DEPTH1),
        .WAIT_STATES (WS1),
        .BASE_ADDR   (BASE1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    dmem_ctrl #(
        .DEPTH_WORDS (DEPTH0),
        .WAIT_STATES (WS0),
        .BASE_ADDR   (BASE0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit which, input logic st, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (which) begin
            bus1.bstart = st;
            bus1.breq   = st;
            bus1.ttype  = ttype_e'(wr);
            bus1.tsize  = tsize_e'(sz);
            bus1.addr   = a;
            bus1.wdata  = wd;
        end else begin
            bus0.bstart = st;
            bus0.breq   = st;
            bus0.ttype  = ttype_e'(wr);
            bus0.tsize  = tsize_e'(sz);
            bus0.addr   = a;
            bus0.wdata  = wd;
        end
    endtask

    // Reference behaviour: byte-addressed memory with natural-alignment and range rules.
    task automatic model(input bit which, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic er, output logic [31:0] rd);
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] idx;
        logic [31:0] w;
        int          depth;
        int          nb;
        int          ln;
        base  = which ? BASE1 : BASE0;
        depth = which ? DEPTH1 : DEPTH0;
        er    = 1'b0;
        rd    = 32'd0;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        if (a < base) begin
            er = 1'b1;
        end
        off = a - base;
        idx = off / 4;
        ln  = int'(off % 4);
        if (nb == 0) begin
            er = 1'b1;
        end else if (ln % nb != 0) begin
            er = 1'b1;
        end
        if (idx >= 32'(depth)) begin
            er = 1'b1;
        end
        if (!er) begin
            w = which ? m1[idx] : m0[idx];
            for (int b = 0; b < nb; b++) begin
                if (wr) begin
                    w[8*(ln+b) +: 8] = wd[8*b +: 8];
                end else begin
                    rd[8*b +: 8] = w[8*(ln+b) +: 8];
                end
            end
            if (wr) begin
                if (which) m1[idx] = w;
                else       m0[idx] = w;
            end
        end
    endtask

    // One complete transfer; keep leaves bstart high so the next call runs back-to-back.
    task automatic do_xfer(input bit which, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input bit keep,
                           input string tag, output logic [31:0] rd_o, output logic er_o);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        int          exp_lat;
        bit          seen;
        exp_lat = int'(which ? WS1 : WS0) + 1 + (pending_done ? 1 : 0);
        drive(which, 1'b1, wr, sz, a, wd);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = which ? bus1.bdone : bus0.bdone;
        end
        rd_o = which ? bus1.rdata : bus0.rdata;
        er_o = which ? bus1.berr : bus0.berr;
        model(which, wr, sz, a, wd, exp_er, exp_rd);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/berr"}, {31'd0, er_o}, {31'd0, exp_er});
        chk({tag, "/rdata"}, rd_o, exp_rd);
        pending_done = keep;
        if (!keep) begin
            drive(which, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            @(posedge clk);
            #1;
            chk({tag, "/pulse"}, {31'd0, which ? bus1.bdone : bus0.bdone}, 32'd0);
            chk({tag, "/hold"}, which ? bus1.rdata : bus0.rdata, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        bit          seen;
        int          r;

        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/bdone1", {31'd0, bus1.bdone}, 32'd0);
        chk("reset/berr1", {31'd0, bus1.berr}, 32'd0);
        chk("reset/rdata1", bus1.rdata, 32'd0);
        chk("reset/bdone0", {31'd0, bus0.bdone}, 32'd0);
        chk("reset/berr0", {31'd0, bus0.berr}, 32'd0);
        chk("reset/rdata0", bus0.rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word write/read with one wait state.
        do_xfer(1'b1, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, "wr_word", rd, er);
        do_xfer(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, "rd_word", rd, er);
        chk("rd_word/const", rd, 32'hDEAD_BEEF);

        // Byte merge into an existing word.
        do_xfer(1'b1, 1'b1, 2'd2, 32'h10, 32'h1234_5678, 1'b0, "wr_base", rd, er);
        do_xfer(1'b1, 1'b1, 2'd0, 32'h11, 32'h0000_00AA, 1'b0, "wr_byte", rd, er);
        do_xfer(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, "rd_merged", rd, er);
        chk("rd_merged/const", rd, 32'h1234_AA78);
        do_xfer(1'b1, 1'b0, 2'd0, 32'h11, 32'h0, 1'b0, "rd_byte", rd, er);
        chk("rd_byte/const", rd, 32'h0000_00AA);

        // Halfword extraction and misaligned half.
        do_xfer(1'b1, 1'b1, 2'd2, 32'h10, 32'hCAFE_8001, 1'b0, "wr_cafe", rd, er);
        do_xfer(1'b1, 1'b0, 2'd1, 32'h12, 32'h0, 1'b0, "rd_half", rd, er);
        chk("rd_half/const", rd, 32'h0000_CAFE);
        do_xfer(1'b1, 1'b1, 2'd1, 32'h11, 32'h0000_1111, 1'b0, "wr_half_mis", rd, er);
        chk("wr_half_mis/const", {31'd0, er}, 32'd1);
        do_xfer(1'b1, 1'b0, 2'd1, 32'h11, 32'h0, 1'b0, "rd_half_mis", rd, er);
        chk("rd_half_mis/const", {31'd0, er}, 32'd1);
        do_xfer(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, "rd_unchanged", rd, er);
        chk("rd_unchanged/const", rd, 32'hCAFE_8001);

        // Out of range and reserved size.
        do_xfer(1'b1, 1'b1, 2'd2, 32'h1000, 32'h5555_5555, 1'b0, "wr_oor", rd, er);
        chk("wr_oor/const", {31'd0, er}, 32'd1);
        do_xfer(1'b1, 1'b0, 2'd3, 32'h10, 32'h0, 1'b0, "rd_rsvd", rd, er);
        chk("rd_rsvd/const", {31'd0, er}, 32'd1);

        // Reset during ACCESS discards the write.
        do_xfer(1'b1, 1'b1, 2'd2, 32'h20, 32'h1111_1111, 1'b0, "wr_prior", rd, er);
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h20, 32'h0000_0055);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus1.bdone) seen = 1'b1;
        end
        chk("rst_abort/bdone", {31'd0, seen}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_xfer(1'b1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, "rd_after_abort", rd, er);
        chk("rd_after_abort/const", rd, 32'h1111_1111);

        // Zero-wait instance with a nonzero base: boundary errors.
        do_xfer(1'b0, 1'b0, 2'd2, BASE0 - 32'd4, 32'h0, 1'b0, "below_base", rd, er);
        chk("below_base/const", {31'd0, er}, 32'd1);
        do_xfer(1'b0, 1'b1, 2'd2, BASE0 + 32'(DEPTH0 * 4), 32'h1, 1'b0, "past_end", rd, er);
        chk("past_end/const", {31'd0, er}, 32'd1);

        // Zero-wait back-to-back: initialise the window, then random traffic with bstart held.
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'b0, 1'b1, 2'd2, BASE0 + 32'(4 * i), $urandom, 1'b1, "b2b_init", rd, er);
        end
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 19);
            a  = BASE0 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (r == 0) a = BASE0 + 32'(DEPTH0 * 4) + 32'($urandom_range(0, 64));
            if (r == 1) a = BASE0 - 32'($urandom_range(1, 16));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            do_xfer(1'b0, wr, sz, a, $urandom, (i != 59), "b2b_rand", rd, er);
        end

        // One-wait instance: random traffic over an initialised window.
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'b1, 1'b1, 2'd2, BASE1 + 32'(4 * i), $urandom, 1'b0, "init1", rd, er);
        end
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 19);
            a  = BASE1 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (r == 0) a = 32'(DEPTH1 * 4) + 32'($urandom_range(0, 1024));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            do_xfer(1'b1, wr, sz, a, $urandom, 1'b0, "rand1", rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
